triangle_feeder: RTL and testbench
==================================

// Module: triangle_feeder
// PURPOSE
//  Transmit side of the triangle vertex interface (nt/xi/yi in, busy/po/xo/yo out on the rasteriser).
//  Queues whole triangles from a host and serialises each as three vertex beats.
//  Then counts the po points the rasteriser returns and reports one result per triangle.
//  Sits between the host/test controller and the triangle rasteriser.
// PARAMETERS
//  CW       3    coordinate width (bits) of x and y
//  DEPTH    4    triangle queue depth (entries; power of 2, >=2)
//  TIMEOUT  255  idle cycles tolerated in WAIT_BUSY/COLLECT before abort
// PORTS
//  clk        in   1      clock; all state on rising edge
//  reset      in   1      asynchronous, active-high reset
//  tri_valid  in   1      host offers a triangle
//  tri_ready  out  1      queue can accept (= !full)
//  tri_data   in   6*CW   {x2,y2,x1,y1,x0,y0}, CW bits each
//  nt         out  1      new-triangle strobe, high on vertex-0 beat only
//  xi         out  CW     vertex x beat
//  yi         out  CW     vertex y beat
//  busy       in   1      rasteriser is producing points
//  po         in   1      point valid this cycle
//  xo         in   CW     point x (qualified by po)
//  yo         in   CW     point y (qualified by po)
//  res_valid  out  1      result available; held until res_ready
//  res_ready  in   1      host accepts result
//  res_count  out  7      po beats counted for the triangle (saturates at 127)
//  res_xsum   out  2*CW   sum of {xo,yo} concatenation mod 2^(2*CW), checksum
//  res_tmo    out  1      triangle aborted by timeout
// BEHAVIOUR
//  Reset (async): queue empty, FSM=IDLE, nt=0, xi=yi=0, res_valid=0, res_count=0, res_xsum=0, res_tmo=0; tri_ready=1 after reset deasserts.
//  Reset mid-triangle abandons it; nt drops immediately, no result emitted.
//  Queue: push when tri_valid&tri_ready; pop on IDLE->SEND0. Push+pop same cycle legal, occupancy unchanged.
//   Full: tri_ready=0, tri_valid ignored. Empty: FSM stays IDLE. Pointers wrap mod DEPTH.
//  FSM (registered outputs):
//   IDLE:      if queue non-empty and res_valid=0 and busy=0 -> SEND0 (pop, clear count/xsum/tmo, timer=0).
//   SEND0:     nt=1, xi/yi=v0 -> SEND1.
//   SEND1:     nt=0, xi/yi=v1 -> SEND2.
//   SEND2:     nt=0, xi/yi=v2 -> WAIT_BUSY.
//   WAIT_BUSY: busy=1 -> COLLECT; else timer++; timer==TIMEOUT -> REPORT with res_tmo=1.
//   COLLECT:   busy=0 -> REPORT; timer clears on every po, else increments; timer==TIMEOUT -> REPORT, res_tmo=1.
//   REPORT:    res_valid=1; res_valid&res_ready -> IDLE (res_valid=0 next cycle).
//  Beats are exactly 3 consecutive cycles; xi/yi return to 0 outside SEND states.
//  po counting: every cycle po=1 while in SEND2, WAIT_BUSY or COLLECT increments res_count (sat 127) and adds {xo,yo} to res_xsum.
//   po in the same cycle busy falls is counted. po in IDLE/SEND0/SEND1/REPORT ignored.
//  Zero-point triangle (busy pulses, no po) -> res_count=0, res_tmo=0.
//  Minimum latency push->nt: 2 cycles (push registered, then IDLE->SEND0).
//  Back-to-back triangles: next SEND0 no earlier than cycle after result handshake.
// STRUCTURE
//  Package triangle_pkg: CW, TRI_W=6*CW, CNT_W=7, FSM state enum (IDLE,SEND0,SEND1,SEND2,WAIT_BUSY,COLLECT,REPORT).
//  Sub-module tri_fifo (DEPTH x TRI_W, valid/ready push, pop strobe, async reset).
//  Top holds FSM, beat mux, timer, counter/checksum, result register.
// TESTING
//  1. Push {v0=(0,0),v1=(4,0),v2=(0,4)}; model rasteriser -> nt high 1 cycle with xi/yi=0/0, then 4/0, 0/4; 15 po beats -> res_count=15, res_tmo=0.
//  2. Push 5 triangles with busy held high -> tri_ready=0 after 4 accepted; 5th accepted as soon as first pops.
//  3. Hold busy=0 after SEND2 -> res_valid with res_tmo=1 exactly TIMEOUT cycles after entering WAIT_BUSY; count=0.
//  4. Hold res_ready=0 with 2 queued -> no second nt until res_ready=1; results arrive in push order.
//  5. Assert reset during SEND1 -> nt/xi/yi=0 same cycle, queue empty, tri_ready=1, no res_valid.
//  6. po with (7,7) on the cycle busy falls -> counted, res_xsum includes 6'o77.

Source files
------------

// File: rtl/triangle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : triangle_pkg
//  Description : Shared widths, FSM state type and helpers for triangle_feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
package triangle_pkg;

    localparam int CW    = 3;
    localparam int TRI_W = 6 * CW;
    localparam int CNT_W = 7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND0     = 3'd1,
        SEND1     = 3'd2,
        SEND2     = 3'd3,
        WAIT_BUSY = 3'd4,
        COLLECT   = 3'd5,
        REPORT    = 3'd6
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/triangle_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : triangle_feeder_if
//  Description : Host queue, rasteriser vertex/point and result signal bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface triangle_feeder_if #(
    parameter int CW = triangle_pkg::CW
);
    import triangle_pkg::*;

    logic              tri_valid;
    logic              tri_ready;
    logic [6*CW-1:0]   tri_data;
    logic              nt;
    logic [CW-1:0]     xi;
    logic [CW-1:0]     yi;
    logic              busy;
    logic              po;
    logic [CW-1:0]     xo;
    logic [CW-1:0]     yo;
    logic              res_valid;
    logic              res_ready;
    logic [CNT_W-1:0]  res_count;
    logic [2*CW-1:0]   res_xsum;
    logic              res_tmo;

    // master: the feeder itself
    modport master (
        input  tri_valid, tri_data, busy, po, xo, yo, res_ready,
        output tri_ready, nt, xi, yi, res_valid, res_count, res_xsum, res_tmo
    );

    // slave: host and rasteriser side
    modport slave (
        output tri_valid, tri_data, busy, po, xo, yo, res_ready,
        input  tri_ready, nt, xi, yi, res_valid, res_count, res_xsum, res_tmo
    );

endinterface
`default_nettype wire

// File: rtl/tri_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tri_fifo
//  Description : DEPTH-entry triangle queue, valid/ready push and pop strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tri_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_push_valid,
    output logic                  o_push_ready,
    input  wire logic [WIDTH-1:0] i_push_data,
    input  wire logic             i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic                  o_empty
);

    localparam int             c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL = DEPTH[c_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_push_ready = (r_count != c_FULL);
    assign o_empty      = (r_count == '0);
    assign o_head       = r_mem[r_rd_ptr];
    assign w_push       = i_push_valid & o_push_ready;
    assign w_pop        = i_pop & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/triangle_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : triangle_feeder
//  Description : Queues triangles, sends three vertex beats, tallies returned
//                points and reports a count/checksum/timeout per triangle.
//  Revision    : 1.0 - initial release
// ============================================================================
module triangle_feeder #(
    parameter int CW      = triangle_pkg::CW,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  wire logic          clk,
    input  wire logic          reset,
    triangle_feeder_if.master  bus
);
    import triangle_pkg::*;

    localparam int              c_TRI_W    = 6 * CW;
    localparam int              c_TW       = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_TW-1:0]     r_timer;
    logic [c_TW-1:0]     w_timer_nxt;
    logic [c_TRI_W-1:0]  w_head;
    logic                w_empty;
    logic                w_pop;
    logic                w_clear;
    logic                w_count_en;
    logic                w_tmo_set;
    logic [2*CW-1:0]     w_beat_nxt;
    logic [4*CW-1:0]     r_tri_hi;
    logic                r_nt;
    logic [CW-1:0]       r_xi;
    logic [CW-1:0]       r_yi;
    logic                r_res_valid;
    logic [CNT_W-1:0]    r_count;
    logic [2*CW-1:0]     r_xsum;
    logic                r_tmo;

    tri_fifo #(
        .WIDTH (c_TRI_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_push_valid (bus.tri_valid),
        .o_push_ready (bus.tri_ready),
        .i_push_data  (bus.tri_data),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_empty      (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_pop       = 1'b0;
        w_clear     = 1'b0;
        w_count_en  = 1'b0;
        w_tmo_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !r_res_valid && !bus.busy) begin
                    w_state_nxt = SEND0;
                    w_pop       = 1'b1;
                    w_clear     = 1'b1;
                    w_timer_nxt = '0;
                end
            end
            SEND0: w_state_nxt = SEND1;
            SEND1: w_state_nxt = SEND2;
            SEND2: begin
                w_count_en  = 1'b1;
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                w_count_en = 1'b1;
                if (bus.busy) begin
                    w_state_nxt = COLLECT;
                end else if (r_timer == c_TMO_LAST) begin
                    w_state_nxt = REPORT;
                    w_tmo_set   = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            COLLECT: begin
                // The point arriving alongside the busy fall is still counted.
                w_count_en = 1'b1;
                if (!bus.busy) begin
                    w_state_nxt = REPORT;
                end else if (bus.po) begin
                    w_timer_nxt = '0;
                end else if (r_timer == c_TMO_LAST) begin
                    w_state_nxt = REPORT;
                    w_tmo_set   = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            REPORT: begin
                if (bus.res_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Vertex 0 comes straight from the queue head on the pop edge.
    always_comb begin
        w_beat_nxt = '0;
        case (w_state_nxt)
            SEND0:   w_beat_nxt = w_head[2*CW-1:0];
            SEND1:   w_beat_nxt = r_tri_hi[2*CW-1:0];
            SEND2:   w_beat_nxt = r_tri_hi[4*CW-1:2*CW];
            default: w_beat_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_tri_hi    <= '0;
            r_nt        <= 1'b0;
            r_xi        <= '0;
            r_yi        <= '0;
            r_res_valid <= 1'b0;
            r_count     <= '0;
            r_xsum      <= '0;
            r_tmo       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_nt        <= (w_state_nxt == SEND0);
            r_xi        <= w_beat_nxt[2*CW-1:CW];
            r_yi        <= w_beat_nxt[CW-1:0];
            r_res_valid <= (w_state_nxt == REPORT);
            if (w_pop) r_tri_hi <= w_head[c_TRI_W-1:2*CW];
            if (w_clear) begin
                r_count <= '0;
                r_xsum  <= '0;
                r_tmo   <= 1'b0;
            end else begin
                if (w_count_en && bus.po) begin
                    r_count <= sat_inc(r_count);
                    r_xsum  <= r_xsum + {bus.xo, bus.yo};
                end
                if (w_tmo_set) r_tmo <= 1'b1;
            end
        end
    end

    assign bus.nt        = r_nt;
    assign bus.xi        = r_xi;
    assign bus.yi        = r_yi;
    assign bus.res_valid = r_res_valid;
    assign bus.res_count = r_count;
    assign bus.res_xsum  = r_xsum;
    assign bus.res_tmo   = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_triangle_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_triangle_feeder
//  Description : Randomised self-checking bench for triangle_feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_triangle_feeder;

    localparam int CW      = 3;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [17:0] exp_q[$];

    triangle_feeder_if #(.CW(CW)) bus();

    triangle_feeder #(
        .CW      (CW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage_point();
        bus.po = 1'($urandom());
        {bus.xo, bus.yo} = 6'($urandom());
    endtask

    task automatic send_point(inout int rem, inout int total, inout logic [5:0] sum);
        logic [5:0] v;
        v = 6'($urandom());
        bus.po = 1'b1;
        {bus.xo, bus.yo} = v;
        rem--;
        total++;
        sum = sum + v;
    endtask

    task automatic push_tri(input logic [17:0] d);
        int n;
        bus.tri_data  = d;
        bus.tri_valid = 1'b1;
        n = 0;
        while (bus.tri_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (bus.tri_ready !== 1'b1)
            begin errors++; $display("FAIL push_ready: tri_ready=%b, required 1", bus.tri_ready); end
        tick();
        bus.tri_valid = 1'b0;
        exp_q.push_back(d);
    endtask

    // Rasteriser model: checks the three beats of the next expected triangle,
    // returns npts points (+1 on the busy-fall cycle) and checks the result.
    task automatic raster(input int npts, input bit fall_po, input logic [5:0] fall_val, input int hold);
        logic [17:0] t;
        logic [5:0]  sum;
        int          rem, total, n, exp_cnt;
        n = 0;
        while (bus.nt !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (bus.nt !== 1'b1) begin
            errors++;
            $display("FAIL nt_wait: nt=%b after %0d cycles, required 1", bus.nt, n);
            return;
        end
        t     = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h0;
        sum   = '0;
        total = 0;
        rem   = npts;
        checks++;
        if ({bus.xi, bus.yi} !== t[5:0])
            begin errors++; $display("FAIL beat0: xi/yi=%o, required %o", {bus.xi, bus.yi}, t[5:0]); end
        garbage_point();
        tick();
        bus.tri_valid = 1'b0;
        checks++;
        if (bus.nt !== 1'b0 || {bus.xi, bus.yi} !== t[11:6])
            begin errors++; $display("FAIL beat1: nt=%b xi/yi=%o, required 0 %o", bus.nt, {bus.xi, bus.yi}, t[11:6]); end
        garbage_point();
        tick();
        checks++;
        if (bus.nt !== 1'b0 || {bus.xi, bus.yi} !== t[17:12])
            begin errors++; $display("FAIL beat2: nt=%b xi/yi=%o, required 0 %o", bus.nt, {bus.xi, bus.yi}, t[17:12]); end
        bus.po = 1'b0;
        if (rem > 0 && $urandom_range(0, 1) == 1) send_point(rem, total, sum);
        tick();
        checks++;
        if (bus.nt !== 1'b0 || {bus.xi, bus.yi} !== 6'o00)
            begin errors++; $display("FAIL beat_idle: nt=%b xi/yi=%o, required 0 00", bus.nt, {bus.xi, bus.yi}); end
        bus.busy = 1'b1;
        bus.po   = 1'b0;
        if (rem > 0 && $urandom_range(0, 1) == 1) send_point(rem, total, sum);
        tick();
        n = 0;
        while (rem > 0 && n < 2000) begin
            bus.po = 1'b0;
            if ($urandom_range(0, 3) != 0) send_point(rem, total, sum);
            tick();
            n++;
        end
        bus.busy = 1'b0;
        bus.po   = fall_po;
        {bus.xo, bus.yo} = fall_val;
        if (fall_po) begin
            total++;
            sum = sum + fall_val;
        end
        tick();
        garbage_point();
        checks++;
        if (bus.res_valid !== 1'b1)
            begin errors++; $display("FAIL res_valid_rise: res_valid=%b, required 1", bus.res_valid); end
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.nt !== 1'b0)
                begin errors++; $display("FAIL res_hold: res_valid=%b nt=%b, required 1 0", bus.res_valid, bus.nt); end
            tick();
            garbage_point();
        end
        bus.res_ready = 1'b1;
        exp_cnt = (total > 127) ? 127 : total;
        checks++;
        if (bus.res_count !== 7'(exp_cnt))
            begin errors++; $display("FAIL res_count: got %0d, required %0d", bus.res_count, exp_cnt); end
        checks++;
        if (bus.res_xsum !== sum)
            begin errors++; $display("FAIL res_xsum: got %o, required %o", bus.res_xsum, sum); end
        checks++;
        if (bus.res_tmo !== 1'b0)
            begin errors++; $display("FAIL res_tmo: got %b, required 0", bus.res_tmo); end
        tick();
        bus.res_ready = 1'b0;
        bus.po        = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.nt !== 1'b0)
            begin errors++; $display("FAIL after_handshake: res_valid=%b nt=%b, required 0 0", bus.res_valid, bus.nt); end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.tri_valid = 1'b0;
        bus.tri_data  = '0;
        bus.busy      = 1'b0;
        bus.po        = 1'b0;
        bus.xo        = '0;
        bus.yo        = '0;
        bus.res_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.nt !== 1'b0 || bus.xi !== 3'd0 || bus.yi !== 3'd0)
            begin errors++; $display("FAIL reset_beat: nt=%b xi=%0d yi=%0d, required 0 0 0", bus.nt, bus.xi, bus.yi); end
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_tmo !== 1'b0)
            begin errors++; $display("FAIL reset_res: res_valid=%b res_tmo=%b, required 0 0", bus.res_valid, bus.res_tmo); end
        checks++;
        if (bus.res_count !== 7'd0 || bus.res_xsum !== 6'd0)
            begin errors++; $display("FAIL reset_sums: count=%0d xsum=%0d, required 0 0", bus.res_count, bus.res_xsum); end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.tri_ready !== 1'b1 || bus.nt !== 1'b0)
            begin errors++; $display("FAIL reset_release: tri_ready=%b nt=%b, required 1 0", bus.tri_ready, bus.nt); end
    endtask

    task automatic test_basic();
        push_tri({3'd0, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0});
        checks++;
        if (bus.nt !== 1'b0)
            begin errors++; $display("FAIL latency_early: nt=%b, required 0", bus.nt); end
        tick();
        checks++;
        if (bus.nt !== 1'b1)
            begin errors++; $display("FAIL latency_2: nt=%b, required 1", bus.nt); end
        raster(15, 1'b0, 6'o00, 0);
    endtask

    task automatic test_zero_point();
        push_tri(18'($urandom()));
        raster(0, 1'b0, 6'o00, 1);
    endtask

    task automatic test_fall_po();
        push_tri(18'($urandom()));
        raster(4, 1'b1, 6'o77, 0);
    endtask

    task automatic test_saturate();
        push_tri(18'($urandom()));
        raster(140, 1'b1, 6'($urandom()), 0);
    endtask

    task automatic test_full();
        logic [17:0] d5;
        bus.busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_tri(18'($urandom()));
        checks++;
        if (bus.tri_ready !== 1'b0)
            begin errors++; $display("FAIL full_ready: tri_ready=%b, required 0", bus.tri_ready); end
        d5 = 18'($urandom());
        bus.tri_data  = d5;
        bus.tri_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.tri_ready !== 1'b0 || bus.nt !== 1'b0)
                begin errors++; $display("FAIL full_hold: tri_ready=%b nt=%b, required 0 0", bus.tri_ready, bus.nt); end
        end
        bus.busy = 1'b0;
        tick();
        checks++;
        if (bus.nt !== 1'b1 || bus.tri_ready !== 1'b1)
            begin errors++; $display("FAIL pop_frees: nt=%b tri_ready=%b, required 1 1", bus.nt, bus.tri_ready); end
        exp_q.push_back(d5);
        for (int i = 0; i < DEPTH + 1; i++)
            raster($urandom_range(0, 20), 1'($urandom()), 6'($urandom()), 0);
    endtask

    task automatic test_hold_result();
        bus.busy = 1'b1;
        push_tri(18'($urandom()));
        push_tri(18'($urandom()));
        bus.busy = 1'b0;
        raster($urandom_range(1, 10), 1'b1, 6'($urandom()), 20);
        raster($urandom_range(1, 10), 1'b0, 6'o00, 0);
    endtask

    task automatic test_timeout(input int wpts);
        logic [5:0] sum;
        logic [5:0] v;
        int         n;
        push_tri(18'($urandom()));
        n = 0;
        while (bus.nt !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.nt !== 1'b1)
            begin errors++; $display("FAIL tmo_nt: nt=%b, required 1", bus.nt); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        sum = '0;
        n   = 0;
        while (bus.res_valid !== 1'b1 && n < 400) begin
            bus.po = 1'b0;
            if (n >= 3 && n < 3 + wpts) begin
                v = 6'($urandom());
                bus.po = 1'b1;
                {bus.xo, bus.yo} = v;
                sum = sum + v;
            end
            tick();
            n++;
        end
        bus.po = 1'b0;
        checks++;
        if (n != 3 + TIMEOUT)
            begin errors++; $display("FAIL tmo_latency: %0d cycles nt->res_valid, required %0d", n, 3 + TIMEOUT); end
        checks++;
        if (bus.res_tmo !== 1'b1 || bus.res_count !== 7'(wpts))
            begin errors++; $display("FAIL tmo_result: tmo=%b count=%0d, required 1 %0d", bus.res_tmo, bus.res_count, wpts); end
        checks++;
        if (bus.res_xsum !== sum)
            begin errors++; $display("FAIL tmo_xsum: got %o, required %o", bus.res_xsum, sum); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0)
            begin errors++; $display("FAIL tmo_handshake: res_valid=%b, required 0", bus.res_valid); end
    endtask

    task automatic test_random();
        int m;
        for (int k = 0; k < 10; k++) begin
            m = $urandom_range(1, 3);
            bus.busy = 1'b1;
            for (int i = 0; i < m; i++) push_tri(18'($urandom()));
            bus.busy = 1'b0;
            for (int i = 0; i < m; i++)
                raster($urandom_range(0, 40), 1'($urandom()), 6'($urandom()), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bus.busy = 1'b1;
        push_tri(18'($urandom()));
        push_tri(18'($urandom()));
        bus.busy = 1'b0;
        n = 0;
        while (bus.nt !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.nt !== 1'b0 || bus.xi !== 3'd0 || bus.yi !== 3'd0)
            begin errors++; $display("FAIL midreset_beat: nt=%b xi=%0d yi=%0d, required 0 0 0", bus.nt, bus.xi, bus.yi); end
        checks++;
        if (bus.tri_ready !== 1'b1 || bus.res_valid !== 1'b0)
            begin errors++; $display("FAIL midreset_state: tri_ready=%b res_valid=%b, required 1 0", bus.tri_ready, bus.res_valid); end
        tick();
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.nt !== 1'b0 || bus.res_valid !== 1'b0)
                begin errors++; $display("FAIL midreset_idle: nt=%b res_valid=%b, required 0 0", bus.nt, bus.res_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_point();
        test_fall_po();
        test_saturate();
        test_full();
        test_hold_result();
        test_timeout(0);
        test_timeout(3);
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
